// File: rtl/s5_apb_bridge_if.sv
// Bundle of the NoC request/response channels and the S5 APB bus seen by s5_apb_bridge.
// master: the bridge side; slave: the NoC initiator plus the APB slave environment.
interface s5_apb_bridge_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [STRB_W-1:0] req_strb;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic [1:0]        rsp_resp;

   logic              S5_PSEL;
   logic              S5_PENABLE;
   logic              S5_PWRITE;
   logic [ADDR_W-1:0] S5_PADDR;
   logic [DATA_W-1:0] S5_PDATA;
   logic [STRB_W-1:0] S5_PSTRB;
   logic [DATA_W-1:0] S5_PRDATA;
   logic              S5_PREADY;
   logic              S5_PSLVERR;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_strb,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_resp,
      input  rsp_ready,
      output S5_PSEL, S5_PENABLE, S5_PWRITE, S5_PADDR, S5_PDATA, S5_PSTRB,
      input  S5_PRDATA, S5_PREADY, S5_PSLVERR
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_strb,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_resp,
      output rsp_ready,
      input  S5_PSEL, S5_PENABLE, S5_PWRITE, S5_PADDR, S5_PDATA, S5_PSTRB,
      output S5_PRDATA, S5_PREADY, S5_PSLVERR
   );
endinterface

// File: rtl/s5_apb_bridge.sv
// Single-outstanding NoC request to APB bridge for slave port 5.
// Optional ACCESS-phase abort enabled by defining S5_APB_TIMEOUT_EN.
module s5_apb_bridge #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input logic             ACLK,
   input logic             ARESET,
   s5_apb_bridge_if.master bus
);
   localparam int unsigned StrbW = DATA_W / 8;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e            state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pdata_q, pdata_d;
   logic [StrbW-1:0]  pstrb_q, pstrb_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]        rsp_resp_q, rsp_resp_d;

`ifdef S5_APB_TIMEOUT_EN
   // Abort on the ACCESS cycle whose wait would bring the count to TIMEOUT_CYCLES.
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] cnt_q, cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pdata_d     = pdata_q;
      pstrb_d     = pstrb_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
`ifdef S5_APB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               state_d   = StSetup;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = bus.req_write;
               paddr_d   = bus.req_addr;
               pdata_d   = bus.req_write ? bus.req_wdata : '0;
               pstrb_d   = bus.req_write ? bus.req_strb : '0;
            end
         end
         StSetup: begin
            state_d   = StAccess;
            penable_d = 1'b1;
`ifdef S5_APB_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end
         StAccess: begin
            if (bus.S5_PREADY) begin
               state_d     = StResp;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = bus.S5_PSLVERR ? 2'b10 : 2'b00;
               rsp_rdata_d = (!pwrite_q && !bus.S5_PSLVERR) ? bus.S5_PRDATA : '0;
            end
`ifdef S5_APB_TIMEOUT_EN
            else if (cnt_q == TimeoutLast) begin
               state_d     = StResp;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = 2'b11;
               rsp_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         StResp: begin
            if (bus.rsp_ready) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q     <= StIdle;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pdata_q     <= '0;
         pstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pdata_q     <= pdata_d;
         pstrb_q     <= pstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

`ifdef S5_APB_TIMEOUT_EN
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_rdata  = rsp_rdata_q;
   assign bus.rsp_resp   = rsp_resp_q;
   assign bus.S5_PSEL    = psel_q;
   assign bus.S5_PENABLE = penable_q;
   assign bus.S5_PWRITE  = pwrite_q;
   assign bus.S5_PADDR   = paddr_q;
   assign bus.S5_PDATA   = pdata_q;
   assign bus.S5_PSTRB   = pstrb_q;

endmodule

// File: tb/tb_s5_apb_bridge.sv
// Directed plus randomized bench for s5_apb_bridge; expectations come from a transaction-level
// model of the bridge rules (latency, response coding, read-data gating, optional abort).
module tb_s5_apb_bridge;
   localparam int unsigned TO = 4;
`ifdef S5_APB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam logic [31:0] CHAIN_ADDR = 32'h0000_0ABC;

   logic ACLK;
   logic ARESET;
   int   tests;
   int   failed;

   s5_apb_bridge_if #(.ADDR_W(32), .DATA_W(32)) bif ();

   s5_apb_bridge #(
      .ADDR_W        (32),
      .DATA_W        (32),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .ACLK  (ACLK),
      .ARESET(ARESET),
      .bus   (bif.master)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full request/response transaction, starting and ending at a negedge in IDLE.
   task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input logic slverr,
                          input logic [31:0] rdata, input int hold, input logic chain);
      logic [31:0] exp_pdata;
      logic [3:0]  exp_pstrb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      bit          to;
      int          acc;
      to        = TO_EN && (waits >= int'(TO));
      acc       = to ? int'(TO) : waits + 1;
      exp_pdata = wr ? wdata : 32'h0;
      exp_pstrb = wr ? strb : 4'h0;
      exp_resp  = to ? 2'b11 : (slverr ? 2'b10 : 2'b00);
      exp_rdata = (!wr && !slverr && !to) ? rdata : 32'h0;

      bif.req_valid = 1'b1;
      bif.req_write = wr;
      bif.req_addr  = addr;
      bif.req_wdata = wdata;
      bif.req_strb  = strb;
      check("req_ready_idle", bif.req_ready, 1);
      @(negedge ACLK);
      bif.req_valid = 1'b0;
      bif.req_wdata = $urandom;
      bif.req_strb  = 4'($urandom);
      check("setup_psel", bif.S5_PSEL, 1);
      check("setup_penable", bif.S5_PENABLE, 0);
      check("setup_paddr", bif.S5_PADDR, addr);
      check("setup_pwrite", bif.S5_PWRITE, wr);
      check("setup_pdata", bif.S5_PDATA, exp_pdata);
      check("setup_pstrb", bif.S5_PSTRB, exp_pstrb);
      check("setup_req_ready", bif.req_ready, 0);
      // PREADY/PSLVERR during SETUP must be ignored.
      bif.S5_PREADY  = 1'($urandom);
      bif.S5_PSLVERR = 1'($urandom);
      for (int c = 0; c < acc; c++) begin
         @(negedge ACLK);
         check("access_psel", bif.S5_PSEL, 1);
         check("access_penable", bif.S5_PENABLE, 1);
         check("access_paddr", bif.S5_PADDR, addr);
         check("access_pdata", bif.S5_PDATA, exp_pdata);
         check("access_pstrb", bif.S5_PSTRB, exp_pstrb);
         check("access_pwrite", bif.S5_PWRITE, wr);
         check("access_rsp_valid", bif.rsp_valid, 0);
         bif.S5_PREADY  = !to && (c == waits);
         bif.S5_PSLVERR = (c == waits) ? slverr : 1'($urandom);
         bif.S5_PRDATA  = (c == waits) ? rdata : $urandom;
      end
      @(negedge ACLK);
      bif.S5_PREADY  = 1'($urandom);
      bif.S5_PSLVERR = 1'($urandom);
      bif.S5_PRDATA  = $urandom;
      check("resp_valid", bif.rsp_valid, 1);
      check("resp_psel", bif.S5_PSEL, 0);
      check("resp_penable", bif.S5_PENABLE, 0);
      check("resp_rdata", bif.rsp_rdata, exp_rdata);
      check("resp_code", bif.rsp_resp, exp_resp);
      check("resp_req_ready", bif.req_ready, 0);
      bif.rsp_ready = (hold == 0);
      for (int h = 0; h < hold; h++) begin
         if (chain) begin
            bif.req_valid = 1'b1;
            bif.req_write = 1'b0;
            bif.req_addr  = CHAIN_ADDR;
         end
         @(negedge ACLK);
         check("hold_valid", bif.rsp_valid, 1);
         check("hold_rdata", bif.rsp_rdata, exp_rdata);
         check("hold_code", bif.rsp_resp, exp_resp);
         check("hold_req_ready", bif.req_ready, 0);
         check("hold_psel", bif.S5_PSEL, 0);
      end
      bif.rsp_ready = 1'b1;
      @(negedge ACLK);
      bif.rsp_ready = 1'b0;
      check("post_rsp_valid", bif.rsp_valid, 0);
      check("post_req_ready", bif.req_ready, 1);
      check("post_psel", bif.S5_PSEL, 0);
   endtask

   initial begin
      tests          = 0;
      failed         = 0;
      bif.req_valid  = 1'b0;
      bif.req_write  = 1'b0;
      bif.req_addr   = '0;
      bif.req_wdata  = '0;
      bif.req_strb   = '0;
      bif.rsp_ready  = 1'b0;
      bif.S5_PRDATA  = '0;
      bif.S5_PREADY  = 1'b0;
      bif.S5_PSLVERR = 1'b0;
      ARESET         = 1'b1;
      #1;
      check("rst_psel", bif.S5_PSEL, 0);
      check("rst_penable", bif.S5_PENABLE, 0);
      check("rst_pwrite", bif.S5_PWRITE, 0);
      check("rst_paddr", bif.S5_PADDR, 0);
      check("rst_pdata", bif.S5_PDATA, 0);
      check("rst_pstrb", bif.S5_PSTRB, 0);
      check("rst_rsp_valid", bif.rsp_valid, 0);
      check("rst_rsp_rdata", bif.rsp_rdata, 0);
      check("rst_rsp_resp", bif.rsp_resp, 0);
      check("rst_req_ready", bif.req_ready, 1);
      @(negedge ACLK);
      @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);

      // Zero-wait write.
      run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 0, 1'b0);
      // Read with three wait states.
      run_txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3, 1'b0, 32'h1234_5678, 0, 1'b0);
      // Read completing with an error.
      run_txn(1'b0, 32'h0000_0030, 32'h0, 4'h0, 1, 1'b1, 32'hCAFE_F00D, 0, 1'b0);
      // Write completing with an error.
      run_txn(1'b1, 32'h0000_0034, 32'h5555_AAAA, 4'h3, 2, 1'b1, 32'h9999_9999, 0, 1'b0);
      // Response back-pressure with a second request waiting; it goes in on the first IDLE cycle.
      run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_F00D, 4, 1'b1);
      run_txn(1'b0, CHAIN_ADDR, 32'h0, 4'h0, 0, 1'b0, 32'h7777_1111, 0, 1'b0);

      // Reset in the middle of ACCESS.
      bif.req_valid = 1'b1;
      bif.req_write = 1'b1;
      bif.req_addr  = 32'h0000_0050;
      bif.req_wdata = 32'h0102_0304;
      bif.req_strb  = 4'hC;
      @(negedge ACLK);
      bif.req_valid = 1'b0;
      bif.S5_PREADY = 1'b0;
      @(negedge ACLK);
      check("pre_rst_penable", bif.S5_PENABLE, 1);
      ARESET = 1'b1;
      #1;
      check("midrst_psel", bif.S5_PSEL, 0);
      check("midrst_penable", bif.S5_PENABLE, 0);
      check("midrst_rsp_valid", bif.rsp_valid, 0);
      check("midrst_req_ready", bif.req_ready, 1);
      @(negedge ACLK);
      ARESET = 1'b0;
      bif.S5_PREADY = 1'b1;
      bif.rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         check("postrst_rsp_valid", bif.rsp_valid, 0);
         check("postrst_psel", bif.S5_PSEL, 0);
      end
      bif.rsp_ready = 1'b0;
      run_txn(1'b1, 32'h0000_0060, 32'hA5A5_5A5A, 4'h5, 0, 1'b0, 32'h0, 0, 1'b0);

`ifdef S5_APB_TIMEOUT_EN
      // PREADY never arrives: abort after TO access cycles.
      run_txn(1'b0, 32'h0000_0070, 32'h0, 4'h0, 20, 1'b0, 32'h1111_2222, 0, 1'b0);
      // PREADY on the last allowed cycle wins.
      run_txn(1'b0, 32'h0000_0074, 32'h0, 4'h0, int'(TO) - 1, 1'b0, 32'h3333_4444, 0, 1'b0);
`endif

      for (int n = 0; n < 30; n++) begin
         logic        wr;
         logic [31:0] addr;
         logic [31:0] wdata;
         logic [3:0]  strb;
         int          waits;
         logic        slverr;
         logic [31:0] rdata;
         int          hold;
         wr     = 1'($urandom);
         addr   = $urandom;
         wdata  = $urandom;
         strb   = 4'($urandom);
         waits  = int'($urandom_range(0, 6));
         slverr = ($urandom_range(0, 3) == 0);
         rdata  = $urandom;
         hold   = int'($urandom_range(0, 2));
         run_txn(wr, addr, wdata, strb, waits, slverr, rdata, hold, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
